// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// The state encoding is also the held-beat count, so occupancy is a direct cast of the state.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // RISC-V "addi x0,x0,0": the canonical bubble for instruction-carrying stages
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [1:0] occ_of(state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    unique case (s)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// One valid/ready payload channel. The producer uses the master modport and the consumer uses
// the slave modport.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 64
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: 1-cycle latency; with SKID_EN a 2-entry skid buffer keeps
// up.ready registered, otherwise a single entry whose ready passes dn.ready through combinationally.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int              DATA_W     = 64,
  parameter bit              SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  pipe_stage_elastic_if.slave   up,
  pipe_stage_elastic_if.master  dn,
  output logic [1:0]            occupancy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic                out_valid;
  logic                in_fire;
  logic                out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = up.valid & up.ready;
  assign out_fire  = out_valid & dn.ready;

  assign dn.valid  = out_valid;
  assign dn.data   = out_valid ? main_q : BUBBLE_VAL;
  assign occupancy = occ_of(state_q);

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q, in_ready_d;

      always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_ready_d = in_ready_q;
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_BUSY;
              main_d  = up.data;
            end
          end
          ST_BUSY: begin
            if (in_fire && out_fire) begin
              main_d = up.data;
            end else if (in_fire) begin
              state_d = ST_FULL;
              skid_d  = up.data;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // The skid entry always holds the younger beat, so it moves forward on drain.
            if (out_fire) begin
              state_d = ST_BUSY;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
        // Computed from next state so ready is a flop output with no path from dn.ready.
        in_ready_d = (state_d != ST_FULL);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q    <= ST_EMPTY;
          main_q     <= BUBBLE_VAL;
          skid_q     <= BUBBLE_VAL;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign up.ready = in_ready_q;
    end else begin : g_single
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (in_fire) begin
          state_d = ST_BUSY;
          main_d  = up.data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_EMPTY;
          main_q  <= BUBBLE_VAL;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end

      assign up.ready = !out_valid | dn.ready;
    end
  endgenerate

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= 2'd2);

  a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_FULL) |-> !up.ready);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !dn.ready && !flush) |=> $stable(dn.data));

endmodule
